seg_display_scheduler: RTL and testbench



---
 rtl/seg_display_scheduler.sv | 134 +++++++++++++
 tb/tb_seg_display_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: time-multiplexes one BCD seven-segment decoder across
// NUM_DIGITS digit positions. Each digit slot is preceded by a blanking gap.
// New values arrive through a valid/ready handshake and are applied only at
// frame boundaries, so a frame never mixes old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   - zero digits above the most-significant nonzero digit are blanked
//               (digit 0 is always shown)
//   undefined - every valid digit is shown, including leading zeros
//
// state | meaning
// ------+-----------------------------------------------------------
// BLANK | all digits off for BLANK_GAP cycles before a slot
// SHOW  | digit idx lit with its active nibble for REFRESH_DIV cycles

module seg_display_scheduler #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    D,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXD = (REFRESH_DIV > BLANK_GAP) ? REFRESH_DIV : BLANK_GAP;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  // With no gap the scheduler never enters BLANK.
  localparam state_t SLOT_START = (BLANK_GAP > 0) ? S_BLANK : S_SHOW;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] active, active_nxt, shadow;
  logic                    pending;
  logic                    slot_end, boundary;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   en_nxt;
  logic [IW-1:0]           msnz;
  logic                    lz_blank, show_ok;

  // Slot sequencing: decide the state, counter and digit for the next cycle.
  always_comb begin
    slot_end  = (state == S_SHOW) ? (cnt == SHOW_LAST) : (cnt == BLANK_LAST);
    boundary  = (state == S_SHOW) && slot_end && (idx == IDX_LAST);
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    if (slot_end) begin
      cnt_nxt = '0;
      if (state == S_SHOW) begin
        state_nxt = SLOT_START;
        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        state_nxt = S_SHOW;
      end
    end
    active_nxt = (boundary && pending) ? shadow : active;
  end

  // Digit decode for the next cycle, using the value that will be active then.
  always_comb begin
    nib    = 4'h0;
    en_nxt = '0;
    msnz   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib       = active_nxt[4*i +: 4];
        en_nxt[i] = 1'b1;
      end
      if (active_nxt[4*i +: 4] != 4'h0) begin
        msnz = IW'(i);
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (idx_nxt > msnz);
`else
    lz_blank = 1'b0;
`endif
    show_ok = (state_nxt == S_SHOW) && (nib <= 4'd9) && !lz_blank;
  end

  // Registered FSM state, handshake and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SLOT_START;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      {A, B, C, D} <= 4'h0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      frame_done <= boundary;
      {A, B, C, D} <= show_ok ? nib : 4'h0;
      digit_en   <= show_ok ? en_nxt : '0;
      if (boundary && pending) begin
        pending    <= 1'b0;
        load_ready <= 1'b1;
      end
      // A transfer on the boundary edge is only possible with pending clear,
      // so it lands in shadow and waits for the following boundary.
      if (load_valid && load_ready) begin
        shadow     <= value_bcd;
        pending    <= 1'b1;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Testbench for seg_display_scheduler (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_GAP=1).
// The driver pushes the expected output vector for every cycle into a queue;
// a monitor on the falling edge pops and compares it against the DUT outputs.

module tb_seg_display_scheduler;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] value_bcd;
  logic        A, B, C, D;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  // expected {load_ready, frame_done, digit_en[3:0], ABCD[3:0]}
  logic [9:0] q[$];

  int          m_p;
  logic [15:0] m_active, m_shadow;
  logic        m_pending, m_ready, m_fd;

  seg_display_scheduler #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BLANK_GAP  (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .value_bcd (value_bcd),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected outputs from the frame phase: phase%5==0 is the gap, then 4 cycles of digit phase/5.
  function automatic logic [9:0] exp_out();
    logic [3:0] de  = 4'h0;
    logic [3:0] bcd = 4'h0;
    logic [3:0] nib;
    int slot = m_p / SLOT;
    int off  = m_p % SLOT;
    int msnz = 0;
    logic show;
    if (off != 0) begin
      nib  = m_active[4*slot +: 4];
      show = (nib <= 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < N; i++)
        if (m_active[4*i +: 4] != 4'h0) msnz = i;
      if (slot > msnz) show = 1'b0;
`endif
      if (show) begin
        de[slot] = 1'b1;
        bcd      = nib;
      end
    end
    return {m_ready, m_fd, de, bcd};
  endfunction

  task automatic model_step(input logic r, input logic lv, input logic [15:0] v);
    logic bnd, acc;
    if (r) begin
      m_p = 0; m_active = '0; m_shadow = '0;
      m_pending = 1'b0; m_ready = 1'b1; m_fd = 1'b0;
    end else begin
      bnd  = (m_p == FRAME - 1);
      acc  = lv && m_ready;
      m_p  = (m_p + 1) % FRAME;
      m_fd = bnd;
      if (bnd && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0; m_ready = 1'b1;
      end
      if (acc) begin
        m_shadow = v; m_pending = 1'b1; m_ready = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, let the DUT sample them, queue the expected result.
  task automatic cyc(input logic r, input logic lv, input logic [15:0] v);
    rst = r; load_valid = lv; value_bcd = v;
    @(posedge clk);
    model_step(r, lv, v);
    q.push_back(exp_out());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic wait_phase(input int target);
    for (int i = 0; i < 2 * FRAME && m_p != target; i++) cyc(1'b0, 1'b0, 16'h0000);
    checks++;
    if (m_p != target) begin
      errors++;
      $display("FAIL wait_phase: reached phase %0d, required %0d", m_p, target);
    end
  endtask

  // Monitor: the DUT presents a display vector every cycle.
  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      act_v = {load_ready, frame_done, digit_en, A, B, C, D};
      checks++;
      cyc_no++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle %0d display: got rdy=%b fd=%b en=%b bcd=%b, expected rdy=%b fd=%b en=%b bcd=%b",
                 cyc_no, act_v[9], act_v[8], act_v[7:4], act_v[3:0],
                 exp_v[9], exp_v[8], exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; value_bcd = '0;
    // reset and idle scanning of zeros
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    idle(2 * FRAME);
    // mid-frame load, then a load attempt while not ready is dropped
    wait_phase(7);
    cyc(1'b0, 1'b1, 16'h2719);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0005);
    idle(2 * FRAME + 5);
    // invalid nibble on digit 2
    cyc(1'b0, 1'b1, 16'h3C21);
    idle(2 * FRAME + 5);
    // reset during digit 2 show
    wait_phase(12);
    cyc(1'b1, 1'b0, 16'h0000);
    idle(FRAME + 5);
    // load accepted on the boundary edge itself waits a full frame
    wait_phase(FRAME - 1);
    cyc(1'b0, 1'b1, 16'h0042);
    idle(2 * FRAME + 5);
    // all zeros
    cyc(1'b0, 1'b1, 16'h0000);
    idle(2 * FRAME + 5);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
